// File: rtl/pcore_uart_pkg.sv
// Shared pcore UART definitions: arbiter state encoding, line-lock defaults
// and small helpers used by the UART transmit arbiter.
package pcore_uart_pkg;

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_e;

    localparam logic [7:0] UART_EOL_CHAR_DEFAULT     = 8'h0A;
    localparam int         UART_LOCK_TIMEOUT_DEFAULT = 1024;

    function automatic logic [1:0] arb_grant(input arb_state_e state);
        case (state)
            GRANT0:  return 2'b01;
            GRANT1:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic arb_state_e arb_other(input arb_state_e state);
        return (state == GRANT0) ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/uart_arb_outreg.sv
// Single-entry valid/ready output register feeding the shared UART
// transmitter; accepts a new byte in the same cycle the old one drains.
module uart_arb_outreg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_tx_ready,
    output logic       o_free,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid
);

    logic       r_valid;
    logic [7:0] r_data;

    assign o_free     = !r_valid || i_tx_ready;
    assign o_tx_data  = r_data;
    assign o_tx_valid = r_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_tx_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of one UART transmitter. Define
// UART_ARB_LINE_LOCK_EN to hold the grant until EOL_CHAR (or timeout).
module uart_tx_arbiter
    import pcore_uart_pkg::*;
#(
    parameter logic [7:0] EOL_CHAR     = UART_EOL_CHAR_DEFAULT,
    parameter int         LOCK_TIMEOUT = UART_LOCK_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req0_data_i,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [7:0] req1_data_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [1:0] grant_o
);

    localparam int               CNT_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_e       r_state;
    logic             r_last_served;
    logic [CNT_W-1:0] r_idle_cnt;

    logic       w_free;
    logic       w_own_valid;
    logic       w_oth_valid;
    logic [7:0] w_own_data;
    logic       w_accept;
    logic       w_byte_release;
    logic       w_timeout;
    logic       w_release;

    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves a variable unassigned (no latch).
    always_comb begin
        w_own_valid = 1'b0;
        w_oth_valid = 1'b0;
        w_own_data  = 8'h00;
        case (r_state)
            GRANT0: begin
                w_own_valid = req0_valid_i;
                w_oth_valid = req1_valid_i;
                w_own_data  = req0_data_i;
            end
            GRANT1: begin
                w_own_valid = req1_valid_i;
                w_oth_valid = req0_valid_i;
                w_own_data  = req1_data_i;
            end
            default: ;
        endcase
    end

    assign req0_ready_o = (r_state == GRANT0) && w_free;
    assign req1_ready_o = (r_state == GRANT1) && w_free;
    assign w_accept     = w_own_valid && w_free;
    assign grant_o      = arb_grant(r_state);

`ifdef UART_ARB_LINE_LOCK_EN
    assign w_byte_release = w_accept && (w_own_data == EOL_CHAR);
`else
    assign w_byte_release = w_accept;
`endif

    assign w_timeout = (r_state != IDLE) && !w_own_valid && (r_idle_cnt == CNT_LAST);
    assign w_release = w_byte_release || w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_served <= 1'b1;
            r_idle_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_idle_cnt <= '0;
                    if (req0_valid_i && req1_valid_i) begin
                        r_state <= r_last_served ? GRANT0 : GRANT1;
                    end else if (req0_valid_i) begin
                        r_state <= GRANT0;
                    end else if (req1_valid_i) begin
                        r_state <= GRANT1;
                    end
                end
                default: begin
                    if (w_release) begin
                        // Hand over directly when the other side is waiting.
                        r_last_served <= (r_state == GRANT1);
                        r_state       <= w_oth_valid ? arb_other(r_state) : IDLE;
                        r_idle_cnt    <= '0;
                    end else if (w_own_valid) begin
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    uart_arb_outreg u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_data     (w_own_data),
        .i_tx_ready (tx_ready_i),
        .o_free     (w_free),
        .o_tx_data  (tx_data_o),
        .o_tx_valid (tx_valid_o)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a
// randomized run scored against per-requester byte queues.
module tb_uart_tx_arbiter;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req0_data_i = 8'h00;
    logic       req0_valid_i = 1'b0;
    logic       req0_ready_o;
    logic [7:0] req1_data_i = 8'h00;
    logic       req1_valid_i = 1'b0;
    logic       req1_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i = 1'b1;
    logic [1:0] grant_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.EOL_CHAR(8'h0A), .LOCK_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_data_i  (req0_data_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req1_data_i  (req1_data_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .grant_o      (grant_o)
    );

    int total = 0;
    int bad   = 0;

    // Source queues and observation logs.
    logic [7:0] src0[$], src1[$], exp0[$], exp1[$];
    logic [7:0] acc0[$], acc1[$], acc_dat[$], out_q[$];
    int         acc_who[$], acc_cyc[$], out_cyc[$];
    logic       acc_oth[$];
    logic [1:0] grant_q[$];
    logic       r0_acc, r1_acc, prev_stall, prev_drop;
    logic [7:0] prev_data;
    int         ncyc;
    int         v_pct = 100;
    int         rdy_pct = 100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_logs();
        src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
        acc0.delete(); acc1.delete(); acc_dat.delete(); out_q.delete();
        acc_who.delete(); acc_cyc.delete(); out_cyc.delete(); acc_oth.delete();
        grant_q.delete();
        r0_acc = 1'b0; r1_acc = 1'b0; prev_stall = 1'b0; prev_drop = 1'b0;
        prev_data = 8'h00; ncyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_data_i = 8'h00; req1_data_i = 8'h00;
        tx_ready_i = 1'b1;
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, observe 1 ns later, well before posedge.
    task automatic cycle();
        logic h0, h1;
        @(negedge clk);
        h0 = req0_valid_i && !r0_acc;
        h1 = req1_valid_i && !r1_acc;
        if (r0_acc) void'(src0.pop_front());
        if (r1_acc) void'(src1.pop_front());
        req0_valid_i = h0 || (src0.size() > 0 && $urandom_range(99) < v_pct);
        req1_valid_i = h1 || (src1.size() > 0 && $urandom_range(99) < v_pct);
        req0_data_i  = (src0.size() > 0) ? src0[0] : 8'h00;
        req1_data_i  = (src1.size() > 0) ? src1[0] : 8'h00;
        tx_ready_i   = ($urandom_range(99) < rdy_pct);
        #1;
        if (prev_stall) begin
            check("hold_valid", tx_valid_o, 1);
            check("hold_data", tx_data_o, prev_data);
        end
        if (prev_drop) check("drop_valid", tx_valid_o, 0);
        check("ready0_rule", req0_ready_o, (grant_o == 2'b01) && (!tx_valid_o || tx_ready_i));
        check("ready1_rule", req1_ready_o, (grant_o == 2'b10) && (!tx_valid_o || tx_ready_i));
        check("grant_onehot", $countones(grant_o) <= 1, 1);
        r0_acc = req0_valid_i && req0_ready_o;
        r1_acc = req1_valid_i && req1_ready_o;
        if (r0_acc) begin
            acc0.push_back(req0_data_i); acc_dat.push_back(req0_data_i);
            acc_who.push_back(0); acc_cyc.push_back(ncyc); acc_oth.push_back(req1_valid_i);
        end
        if (r1_acc) begin
            acc1.push_back(req1_data_i); acc_dat.push_back(req1_data_i);
            acc_who.push_back(1); acc_cyc.push_back(ncyc); acc_oth.push_back(req0_valid_i);
        end
        if (tx_valid_o && tx_ready_i) begin
            out_q.push_back(tx_data_o);
            out_cyc.push_back(ncyc);
        end
        prev_stall = tx_valid_o && !tx_ready_i;
        prev_data  = tx_data_o;
        prev_drop  = tx_valid_o && tx_ready_i && !r0_acc && !r1_acc;
        grant_q.push_back(grant_o);
        ncyc++;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((src0.size() > 0 || src1.size() > 0 || tx_valid_o) && k < budget) begin
            cycle();
            k++;
        end
        check("drain_done", src0.size() > 0 || src1.size() > 0 || tx_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, zeros, first_g;
        logic seen;
        logic [7:0] exp_b[6];
        logic [7:0] ra, rb;

        // Reset values, with a requester already asserting valid.
        req0_valid_i = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_tx_valid", tx_valid_o, 0);
        check("rst_tx_data", tx_data_o, 8'h00);
        check("rst_grant", grant_o, 2'b00);
        check("rst_ready0", req0_ready_o, 0);
        check("rst_ready1", req1_ready_o, 0);

        // "A\n" from requester 0.
        do_reset();
        v_pct = 100; rdy_pct = 100;
        src0.push_back(8'h41); src0.push_back(8'h0A);
        drain(50);
        check("a_count", out_q.size(), 2);
        check("a_byte0", out_q[0], 8'h41);
        check("a_byte1", out_q[1], 8'h0A);
        check("a_latency", out_cyc[0], acc_cyc[0] + 1);
`ifdef UART_ARB_LINE_LOCK_EN
        check("a_gap", out_cyc[1] - out_cyc[0], 1);
`else
        check("a_gap", out_cyc[1] - out_cyc[0], 2);
`endif
        first_g = 0;
        for (int i = grant_q.size() - 1; i >= 0; i--) if (grant_q[i] != 2'b00) first_g = grant_q[i];
        check("a_first_grant", first_g, 2'b01);
        check("a_final_grant", grant_q[grant_q.size() - 1], 2'b00);

        // Both requesters stream a line each.
        do_reset();
        src0 = '{8'h61, 8'h62, 8'h0A};
        src1 = '{8'h78, 8'h79, 8'h0A};
`ifdef UART_ARB_LINE_LOCK_EN
        exp_b = '{8'h61, 8'h62, 8'h0A, 8'h78, 8'h79, 8'h0A};
`else
        exp_b = '{8'h61, 8'h78, 8'h62, 8'h79, 8'h0A, 8'h0A};
`endif
        drain(50);
        check("b_count", out_q.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("b_byte%0d", i), out_q[i], exp_b[i]);
        zeros = 0;
        for (int c = acc_cyc[0]; c <= acc_cyc[acc_cyc.size() - 1]; c++)
            if (grant_q[c] == 2'b00) zeros++;
        check("b_no_bubble", zeros, 0);

        // Backpressure: byte held for 5 stalled cycles, then delivered once.
        do_reset();
        src0 = '{8'h55, 8'h0A};
        rdy_pct = 0;
        n = 0;
        while (!tx_valid_o && n < 10) begin cycle(); n++; end
        check("c_registered", tx_valid_o, 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("c_stall_data", tx_data_o, 8'h55);
            check("c_stall_ready0", req0_ready_o, 0);
        end
        rdy_pct = 100;
        drain(50);
        check("c_count", out_q.size(), 2);
        check("c_byte0", out_q[0], 8'h55);
        check("c_byte1", out_q[1], 8'h0A);

        // Timeout: owner goes quiet while the other side waits.
        do_reset();
        @(negedge clk);
        req0_valid_i = 1'b1; req0_data_i = 8'h41;
`ifdef UART_ARB_LINE_LOCK_EN
        @(negedge clk);
`endif
        @(negedge clk);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1; req1_data_i = 8'h78;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (grant_o == 2'b10) begin seen = 1'b1; break; end
            if (grant_o == 2'b01) n++;
            @(negedge clk);
        end
        check("d_switched", seen, 1);
        check("d_idle_cycles", n, TMO);

        // Reset while a byte is registered and stalled.
        do_reset();
        src0 = '{8'hC3};
        rdy_pct = 0;
        n = 0;
        while (!tx_valid_o && n < 10) begin cycle(); n++; end
        check("e_registered", tx_valid_o, 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("e_tx_valid", tx_valid_o, 0);
        check("e_tx_data", tx_data_o, 8'h00);
        check("e_grant", grant_o, 2'b00);
        check("e_ready0", req0_ready_o, 0);
        do_reset();
        rdy_pct = 100;
        for (int i = 0; i < 10; i++) cycle();
        check("e_never_emitted", out_q.size(), 0);

        // Randomized traffic: one sparse round, one streaming round.
        do_reset();
        for (int round = 0; round < 2; round++) begin
            clear_logs();
            v_pct   = (round == 0) ? 60 : 100;
            rdy_pct = (round == 0) ? 70 : 100;
            for (int i = 0; i < 30; i++) begin
                ra = ($urandom_range(5) == 0) ? 8'h0A : 8'($urandom);
                rb = ($urandom_range(5) == 0) ? 8'h0A : 8'($urandom);
                src0.push_back(ra); exp0.push_back(ra);
                src1.push_back(rb); exp1.push_back(rb);
            end
            drain(3000);
            check("r_acc0_count", acc0.size(), exp0.size());
            check("r_acc1_count", acc1.size(), exp1.size());
            for (int i = 0; i < exp0.size() && i < acc0.size(); i++)
                check("r_acc0_order", acc0[i], exp0[i]);
            for (int i = 0; i < exp1.size() && i < acc1.size(); i++)
                check("r_acc1_order", acc1[i], exp1[i]);
            check("r_out_count", out_q.size(), acc_dat.size());
            for (int i = 0; i < out_q.size() && i < acc_dat.size(); i++)
                check("r_out_order", out_q[i], acc_dat[i]);
`ifndef UART_ARB_LINE_LOCK_EN
            for (int i = 0; i + 1 < acc_who.size(); i++)
                if (acc_oth[i]) check("r_round_robin", acc_who[i + 1], 1 - acc_who[i]);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter EOL_CHAR, default 8'h0A, the end-of-line byte that releases a line lock.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, the idle cycles after which a held grant is released.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req0_data_i  input  8  byte from requester 0 (secure UART).
REQ-006 SHALL have port req0_valid_i  input  1  requester 0 byte valid.
REQ-007 SHALL have port req0_ready_o  output  1  requester 0 byte accepted when high with valid.
REQ-008 SHALL have ports req1_data_i / req1_valid_i / req1_ready_o  with the same widths and meanings for requester 1 (non-secure UART).
REQ-009 SHALL have port tx_data_o  output  8  byte to the shared UART transmitter.
REQ-010 SHALL have port tx_valid_o  output  1  tx_data_o valid.
REQ-011 SHALL have port tx_ready_i  input  1  transmitter accepts byte.
REQ-012 SHALL have port grant_o  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-013 SHALL implement states IDLE, GRANT0, GRANT1.
REQ-014 In IDLE, when exactly one requester is valid, the arbiter SHALL move to that requester's GRANT state on the next cycle.
REQ-015 In IDLE, when both requesters are valid, the arbiter SHALL grant the requester not served last (round-robin); last_served SHALL reset to 1, so requester 0 wins first.
REQ-016 reqN_ready_o SHALL be high only in GRANTN and only when the output register is free: !tx_valid_o || tx_ready_i.
REQ-017 Output register: a byte accepted in cycle N SHALL appear on tx_data_o with tx_valid_o=1 in cycle N+1.
REQ-018 tx_data_o SHALL be held stable while tx_valid_o=1 && tx_ready_i=0.
REQ-019 When tx_ready_i=1 and no new byte is accepted in the same cycle, tx_valid_o SHALL drop to 0 in the next cycle.
REQ-020 Release: the arbiter SHALL switch directly to the other GRANT state if the other requester is valid in the release cycle, otherwise go to IDLE; last_served SHALL update on release.
REQ-021 Timeout counter SHALL count consecutive GRANT cycles in which the owner's valid is low.
REQ-022 The timeout counter SHALL clear on any accepted byte and on any state change.
REQ-023 When the timeout counter reaches LOCK_TIMEOUT-1, the grant SHALL be released.
REQ-024 Simultaneous release and other-requester valid SHALL yield no IDLE bubble.
REQ-025 Simultaneous accept and tx_ready_i SHALL accept the new byte (full throughput, one byte per cycle).
REQ-026 Release SHALL NOT clear an already-registered byte; the byte SHALL still be delivered.
REQ-027 grant_o SHALL reflect the state combinationally.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, tx_valid_o=0, tx_data_o=8'h00, grant_o=2'b00, both ready outputs 0, timeout counter 0, last_served=1.
REQ-029 Reset mid-transfer SHALL drop the pending byte without emitting it.

Configuration
REQ-030 With UART_ARB_LINE_LOCK_EN defined, the grant SHALL release only on acceptance of EOL_CHAR from the owner, or on timeout.
REQ-031 Without UART_ARB_LINE_LOCK_EN, the grant SHALL release after every accepted byte (byte-interleaved round-robin); the timeout SHALL still apply.

Structure
REQ-032 The state enum (IDLE/GRANT0/GRANT1) SHALL be defined in the shared pcore UART package.
REQ-033 The default EOL and timeout constants SHALL be defined in the shared pcore UART package.
REQ-034 The module SHALL contain a single sub-module, uart_arb_outreg, holding the valid/ready output register.

Verification
REQ-035 Reset release; req0 sends "A\n" (8'h41, 8'h0A) with tx_ready_i=1 -> tx_data_o shows 41, 0A on consecutive cycles starting one cycle after acceptance; grant_o=01, then 00.
REQ-036 LINE_LOCK_EN; both requesters valid; req0 sends "ab\n", req1 sends "xy\n" -> output is 61 62 0A 78 79 0A with no interleaving; grant_o 01 then 10 with no idle cycle.
REQ-037 No LINE_LOCK_EN; both requesters stream continuously -> output alternates req0/req1 byte by byte, starting with req0.
REQ-038 tx_ready_i held 0 for 5 cycles with a byte registered -> tx_data_o stable, reqN_ready_o=0; on ready, the byte is delivered exactly once.
REQ-039 LINE_LOCK_EN, LOCK_TIMEOUT=8; req0 sends 8'h41 then stalls while req1 is valid -> grant switches to req1 after 8 idle cycles.
REQ-040 Assert rst_n low while tx_valid_o=1 -> all outputs at reset values immediately; that byte is never emitted.
